// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demultiplexer.
// Each accepted input beat is written into exactly one of four one-entry
// output registers, chosen by in_sel. Every channel also keeps a saturating
// count of the beats its consumer has taken.
//
// Handshake: a transfer happens on a rising clk edge when valid & ready are
// both high on that edge. The producer holds payload stable while valid=1 and
// ready=0. ready never depends on valid on the same interface. in_ready for a
// given in_sel is high when that channel is empty or is draining this cycle.
module stream_demux_1to4 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_sel,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  input  logic                  cnt_clr,
  output logic [4*CNT_W-1:0]    beat_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]        r_valid;
  logic [DATA_W-1:0] r_data [4];
  logic [CNT_W-1:0]  r_cnt  [4];

  logic [3:0] w_sel_oh;
  logic [3:0] w_drain;
  logic [3:0] w_load;
  logic       w_in_ready;
  logic       w_accept;

  // Decode the destination channel. An unknown select decodes to no channel,
  // so an undriven in_sel while idle cannot make any output unknown.
  always_comb begin
    w_sel_oh = 4'b0000;
    case (in_sel)
      2'd0:    w_sel_oh = 4'b0001;
      2'd1:    w_sel_oh = 4'b0010;
      2'd2:    w_sel_oh = 4'b0100;
      2'd3:    w_sel_oh = 4'b1000;
      default: w_sel_oh = 4'b0000;
    endcase
  end

  // A channel can take a new beat when empty or when its beat leaves this cycle.
  assign w_drain    = r_valid & out_ready;
  assign w_in_ready = |(w_sel_oh & (~r_valid | out_ready));
  assign w_accept   = in_valid & w_in_ready;
  assign w_load     = w_sel_oh & {4{w_accept}};

  // Valid flags: a load wins over a drain so back-to-back beats keep valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 4'b0000;
    end else begin
      r_valid <= (r_valid & ~w_drain) | w_load;
    end
  end

  // Payload registers: only the selected channel is written; others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_data[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) r_data[k] <= in_data;
      end
    end
  end

  // Delivered-beat counters: clear has priority, increments stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_clr) begin
          r_cnt[k] <= '0;
        end else if (w_drain[k] && (r_cnt[k] != CNT_MAX)) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Pack per-channel registers onto the flat output buses.
  always_comb begin
    out_data = '0;
    beat_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      out_data[k*DATA_W +: DATA_W] = r_data[k];
      beat_cnt[k*CNT_W  +: CNT_W]  = r_cnt[k];
    end
  end

  assign out_valid = r_valid;
  assign in_ready  = w_in_ready;

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Bench for stream_demux_1to4: a 16-bit-counter instance carries the data
// checks, a 4-bit-counter instance on the same stimulus covers saturation.
module tb_stream_demux_1to4;

  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [4*DW-1:0]  out_data;
  logic             cnt_clr;
  logic [4*CW-1:0]  beat_cnt;

  logic             in_ready4;
  logic [3:0]       out_valid4;
  logic [4*DW-1:0]  out_data4;
  logic [4*CW4-1:0] beat_cnt4;

  stream_demux_1to4 #(.DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .cnt_clr(cnt_clr),
    .beat_cnt(beat_cnt)
  );

  stream_demux_1to4 #(.DATA_W(DW), .CNT_W(CW4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .cnt_clr(cnt_clr),
    .beat_cnt(beat_cnt4)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q [4][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int k);
    return beat_cnt[k*CW +: CW];
  endfunction

  function automatic logic [CW4-1:0] cnt4(input int k);
    return beat_cnt4[k*CW4 +: CW4];
  endfunction

  // Monitor on the falling edge: check leaving beats first, then record accepted ones.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_ch%0d: got beat 0x%0h, expected none (t=%0t)",
                     k, out_data[k*DW +: DW], $time);
          end else begin
            check($sformatf("data_ch%0d", k), 64'(out_data[k*DW +: DW]), 64'(exp_q[k].pop_front()));
          end
        end
      end
      if (in_valid && in_ready) exp_q[in_sel].push_back(in_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] sel, input logic [DW-1:0] d,
                       input logic [3:0] rdy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic          v;
    logic [1:0]    sel;
    logic [DW-1:0] data;
    logic [3:0]    rdy;
    logic          exp_rdy;
    logic [3:0]    exp_ov;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // idle + reset-state vectors: every sel must be ready when all channels are empty
    for (int k = 0; k < 4; k++) tbl[k] = '{1'b0, 2'(k), 8'h00, 4'b0000, 1'b1, 4'b0000};
    // back-to-back one beat per channel, all consumers ready
    tbl[4] = '{1'b1, 2'd0, 8'h11, 4'b1111, 1'b1, 4'b0001};
    tbl[5] = '{1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010};
    tbl[6] = '{1'b1, 2'd2, 8'h33, 4'b1111, 1'b1, 4'b0100};
    tbl[7] = '{1'b1, 2'd3, 8'h44, 4'b1111, 1'b1, 4'b1000};
    tbl[8] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000};

    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_beat_cnt",  beat_cnt,       64'h0);
    tick();

    // table: reset-state readiness and back-to-back distribution
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
      tick();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
    end
    for (int k = 0; k < 4; k++) check($sformatf("t2_cnt%0d", k), 64'(cnt(k)), 64'd1);

    // stall on ch2, bypass to ch0, then resume ch2 with drain+load in one cycle
    drive(1'b1, 2'd2, 8'hA0, 4'b1011);
    #1 check("t3_a0_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b1, 2'd2, 8'hA1, 4'b1011);
    #1 check("t3_a1_stall", 64'(in_ready), 64'd0);
    tick();
    check("t3_hold_valid", 64'(out_valid), 64'b0100);
    check("t3_hold_data",  64'(out_data[2*DW +: DW]), 64'hA0);
    check("t3_still_stall", 64'(in_ready), 64'd0);
    tick();
    drive(1'b1, 2'd0, 8'hB0, 4'b1011);
    #1 check("t3_b0_ready", 64'(in_ready), 64'd1);
    tick();
    check("t3_b0_valid", 64'(out_valid), 64'b0101);
    drive(1'b1, 2'd2, 8'hA1, 4'b1011);
    #1 check("t3_a1_stall2", 64'(in_ready), 64'd0);
    tick();
    check("t3_ch0_drained", 64'(out_valid), 64'b0100);
    drive(1'b1, 2'd2, 8'hA1, 4'b1111);
    #1 check("t3_a1_ready", 64'(in_ready), 64'd1);
    tick();
    check("t3_a1_valid", 64'(out_valid), 64'b0100);
    check("t3_a1_data",  64'(out_data[2*DW +: DW]), 64'hA1);
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    tick();
    check("t3_empty", 64'(out_valid), 64'h0);

    // clear counters while idle
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt",  beat_cnt,        64'h0);
    check("clr_cnt4", 64'(beat_cnt4),  64'h0);

    // 16-beat stream to ch3 at full throughput
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'd3, 8'($urandom_range(0, 255)), 4'b1000);
      #1 check($sformatf("t4_ready%0d", i), 64'(in_ready), 64'd1);
      tick();
      check($sformatf("t4_valid%0d", i), 64'(out_valid[3]), 64'd1);
    end
    drive(1'b0, 2'd0, 8'h00, 4'b1000);
    tick();
    check("t4_done_valid", 64'(out_valid[3]), 64'd0);
    check("t4_cnt3", 64'(cnt(3)), 64'd16);

    // 20 beats to ch1: the 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'd1, 8'($urandom_range(0, 255)), 4'b0010);
      tick();
      if (i == 15) begin
        check("t5_cnt1_mid",  64'(cnt(1)),  64'd15);
        check("t5_cnt4_mid",  64'(cnt4(1)), 64'd15);
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'b0010);
    tick();
    check("t5_cnt1_20",  64'(cnt(1)),  64'd20);
    check("t5_cnt4_sat", 64'(cnt4(1)), 64'd15);
    // clear in the same cycle as a drain: clear wins
    drive(1'b1, 2'd1, 8'h5A, 4'b0000);
    tick();
    drive(1'b0, 2'd0, 8'h00, 4'b0010);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t5_clr_cnt1",  64'(cnt(1)),  64'd0);
    check("t5_clr_cnt4",  64'(cnt4(1)), 64'd0);
    check("t5_clr_cnt3",  64'(cnt(3)),  64'd0);

    // fill all channels, then reset asynchronously mid-cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'(8'hC0 + k), 4'b0000);
      tick();
    end
    check("t6_full", 64'(out_valid), 64'hF);
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #1;
    check("t6_async_valid", 64'(out_valid), 64'h0);
    check("t6_async_data",  64'(out_data),  64'h0);
    check("t6_async_ready", 64'(in_ready),  64'd1);
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_post_valid%0d", i), 64'(out_valid), 64'h0);
    end
    check("t6_post_cnt", beat_cnt, 64'h0);

    for (int k = 0; k < 4; k++) check($sformatf("end_q%0d_empty", k), 64'(exp_q[k].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
